mem_ctrl: RTL

//  Byte-serial memory controller and arbiter between the fetch stage and the MEM stage.
//  - Fetch requests read one 32-bit instruction. MEM requests read or write 1, 2 or 4 bytes.
//  - Each request is sequenced as one byte access per cycle on the 8-bit RAM port; read bytes are assembled little-endian.
//  - Sits directly upstream of IF (supplies its fetched instruction words) and of MEM.
//  - Raises the MEM-side stall request to the pipeline controller.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, access-length
// codes and the length-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Length code 3 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetch and MEM requests onto an 8-bit
// RAM port; one byte per cycle, read bytes assembled little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  nbytes_q;
  logic        fetch_q;
  logic [23:0] wdata_q;
  logic [31:0] asm_q;
  logic [31:0] asm_d;
  logic [1:0]  cap_idx;
  logic [2:0]  last_idx;
  logic        busy_done;
  logic        mem_grant;
  logic        if_grant;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  assign stall_req_o = mem_req_i & ~mem_done_o;

  // No new grant in a cycle that is presenting a done pulse.
  assign busy_done = if_done_o | mem_done_o;
  assign mem_grant = mem_req_i & ~busy_done;
  assign if_grant  = if_req_i & ~mem_req_i & ~if_cancel_i & ~busy_done;

  assign last_idx = 3'(nbytes_q - 3'd1);
  assign cap_idx  = 2'(cnt_q - 3'd1);

  // In RD, cnt_q==k+1 means the byte for A+k is on ram_din_i this cycle.
  always_comb begin
    asm_d = asm_q;
    if (cnt_q != 3'd0) begin
      asm_d[{cap_idx, 3'b000} +: 8] = ram_din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      fetch_q     <= 1'b0;
      wdata_q     <= 24'h0;
      asm_q       <= 32'h0;
      if_done_o   <= 1'b0;
      if_inst_o   <= 32'h0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= 32'h0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'h0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 3'd0;
          asm_q <= 32'h0;
          if (mem_grant) begin
            fetch_q    <= 1'b0;
            nbytes_q   <= len_bytes(mem_len_i);
            ram_addr_o <= mem_addr_i[ADDR_W-1:0];
            ram_wr_o   <= mem_we_i;
            ram_dout_o <= mem_we_i ? mem_wdata_i[7:0] : 8'h0;
            wdata_q    <= mem_wdata_i[31:8];
            state_q    <= mem_we_i ? ST_WR : ST_RD;
          end else if (if_grant) begin
            fetch_q    <= 1'b1;
            nbytes_q   <= 3'd4;
            ram_addr_o <= if_addr_i[ADDR_W-1:0];
            ram_wr_o   <= 1'b0;
            state_q    <= ST_RD;
          end
        end
        ST_RD: begin
          asm_q <= asm_d;
          cnt_q <= cnt_q + 3'd1;
          if (fetch_q && if_cancel_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == nbytes_q) begin
            state_q <= ST_IDLE;
            if (fetch_q) begin
              if_done_o <= 1'b1;
              if_inst_o <= asm_d;
            end else begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= asm_d;
            end
          end else if (cnt_q < last_idx) begin
            ram_addr_o <= ram_addr_o + ADDR_W'(1);
          end
        end
        ST_WR: begin
          if (cnt_q == last_idx) begin
            ram_wr_o   <= 1'b0;
            mem_done_o <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_addr_o <= ram_addr_o + ADDR_W'(1);
            ram_dout_o <= wdata_q[7:0];
            wdata_q    <= {8'h0, wdata_q[23:8]};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
